// File: rtl/apb_slave_regfile.sv
// APB completer with a bank of 32-bit registers; the top register is read-only and mirrors STATUS_IN.
// Latency: one setup cycle, then WAIT_CYCLES+1 access cycles; PREADY is high in the last access cycle.
// Backpressure: PREADY is held low for WAIT_CYCLES access cycles; dropping PSELx mid-wait aborts cleanly.
module apb_slave_regfile #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic                     PCLK,
  input  logic                     PRESETn,
  input  logic [31:0]              PADDR,
  input  logic [2:0]               PPROT,
  input  logic                     PSELx,
  input  logic                     PENABLE,
  input  logic                     PWRITE,
  input  logic [31:0]              PWDATA,
  input  logic [3:0]               PSTRB,
  output logic                     PREADY,
  output logic [31:0]              PRDATA,
  output logic                     PSLVERR,
  input  logic [31:0]              STATUS_IN,
  output logic [32*NUM_REGS-1:0]   REG_OUT
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);
  localparam logic [5:0]  RO_IDX  = 6'(NUM_REGS - 1);
  localparam logic [31:0] SPAN    = 32'(4 * NUM_REGS);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] regs_q [NUM_REGS-1];

  logic [31:0] off;
  logic [5:0]  idx;
  logic        err;
  logic        wr_en;
  logic [31:0] rd_val;
  logic        unused_prot;

  // Protection attributes carry no meaning for this register bank.
  assign unused_prot = ^PPROT;

  assign off = PADDR - BASE_ADDR;
  assign idx = off[7:2];
  assign err = (PADDR < BASE_ADDR) | (off[1:0] != 2'b00) | (off >= SPAN) |
               (PWRITE & (idx == RO_IDX));

  assign PREADY  = (state_q == S_WAIT) & PSELx & PENABLE & (cnt_q == 4'd0);
  assign PSLVERR = PREADY & err;
  assign wr_en   = PREADY & PWRITE & ~err;
  assign PRDATA  = (PREADY & ~PWRITE & ~err) ? rd_val : 32'h0;

  // State and wait counter; reset drops any in-flight transfer.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: setup loads the counter, access counts down to zero and never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (PSELx && !PENABLE) begin
          state_d = S_WAIT;
          cnt_d   = WAIT_LD;
        end
      end
      S_WAIT: begin
        if (!PSELx) begin
          state_d = S_IDLE;
        end else if (PENABLE) begin
          if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
          else               state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (PSELx && !PENABLE) begin
          state_d = S_WAIT;
          cnt_d   = WAIT_LD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Byte-masked register writes, committed only in an error-free write PREADY cycle.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < NUM_REGS - 1; i++) regs_q[i] <= 32'h0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_REGS - 1; i++) begin
        if (idx == 6'(i)) begin
          for (int b = 0; b < 4; b++) begin
            if (PSTRB[b]) regs_q[i][8*b +: 8] <= PWDATA[8*b +: 8];
          end
        end
      end
    end
  end

  // Read mux; the top index returns the live status input.
  always_comb begin
    rd_val = 32'h0;
    for (int i = 0; i < NUM_REGS - 1; i++) begin
      if (idx == 6'(i)) rd_val = regs_q[i];
    end
    if (idx == RO_IDX) rd_val = STATUS_IN;
  end

  for (genvar g = 0; g < NUM_REGS - 1; g++) begin : g_reg_out
    assign REG_OUT[32*g +: 32] = regs_q[g];
  end
  assign REG_OUT[32*(NUM_REGS-1) +: 32] = STATUS_IN;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: three instances (WAIT_CYCLES 2, 3, 0) on a shared APB bus.
// Latency: expected responses are queued when a transfer is issued and compared when PREADY is seen.
// Backpressure: every wait for PREADY is bounded; an expired bound counts as a failure.
module tb_apb_slave_regfile;

  logic         clk;
  logic         rst_n;
  logic [31:0]  paddr;
  logic [2:0]   pprot;
  logic         penable;
  logic         pwrite;
  logic [31:0]  pwdata;
  logic [3:0]   pstrb;
  logic [31:0]  status;
  logic         psel    [3];
  logic         pready  [3];
  logic [31:0]  prdata  [3];
  logic         pslverr [3];
  logic [255:0] reg_out [3];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  typedef struct {
    int          t;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        keep;
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } xfer_t;

  exp_t exp_q[$];

  apb_slave_regfile #(.BASE_ADDR(32'h0000_0000), .NUM_REGS(8), .WAIT_CYCLES(2)) dut_w2 (
    .PCLK(clk), .PRESETn(rst_n), .PADDR(paddr), .PPROT(pprot), .PSELx(psel[0]),
    .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb),
    .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0]),
    .STATUS_IN(status), .REG_OUT(reg_out[0]));

  apb_slave_regfile #(.BASE_ADDR(32'h4000_0100), .NUM_REGS(8), .WAIT_CYCLES(3)) dut_w3 (
    .PCLK(clk), .PRESETn(rst_n), .PADDR(paddr), .PPROT(pprot), .PSELx(psel[1]),
    .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb),
    .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERR(pslverr[1]),
    .STATUS_IN(status), .REG_OUT(reg_out[1]));

  apb_slave_regfile #(.BASE_ADDR(32'h0000_1000), .NUM_REGS(8), .WAIT_CYCLES(0)) dut_w0 (
    .PCLK(clk), .PRESETn(rst_n), .PADDR(paddr), .PPROT(pprot), .PSELx(psel[2]),
    .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb),
    .PREADY(pready[2]), .PRDATA(prdata[2]), .PSLVERR(pslverr[2]),
    .STATUS_IN(status), .REG_OUT(reg_out[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // One APB transfer on instance t; returns at the negedge of the PREADY cycle (keep=1) or one cycle later.
  task automatic apb_do(input int t, input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic keep,
                        output logic [31:0] rd, output logic er, output int acc, output logic tout);
    @(posedge clk); #1;
    psel[t] = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    @(posedge clk); #1;
    penable = 1'b1;
    acc = 0; tout = 1'b1; rd = 32'h0; er = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      acc++;
      if (pready[t]) begin
        rd = prdata[t]; er = pslverr[t]; tout = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    if (!keep || tout) begin
      @(posedge clk); #1;
      psel[t] = 1'b0; penable = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic seen;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int t = 0; t < 3; t++) begin
      checks++;
      if ({pready[t], pslverr[t], prdata[t], reg_out[t]} !== '0) begin
        failures++;
        $display("FAIL reset_state[%0d] got rdy=%b err=%b rdata=%h regs=%h want all zero",
                 t, pready[t], pslverr[t], prdata[t], reg_out[t]);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    // Preload reg1 of the WAIT_CYCLES=2 instance, then read it and reset inside the PREADY cycle.
    begin
      logic [31:0] rd; logic er; int acc; logic tout;
      exp_q.push_back('{32'h0, 1'b0, 3});
      apb_do(0, 1'b1, 32'h4, 32'hA5A5_A5A5, 4'hF, 1'b0, rd, er, acc, tout);
      begin
        exp_t e = exp_q.pop_front();
        checks++;
        if (tout || rd !== e.rdata || er !== e.err || acc !== e.acc) begin
          failures++;
          $display("FAIL reset_preload got rdata=%h err=%b acc=%0d tout=%b want rdata=%h err=%b acc=%0d",
                   rd, er, acc, tout, e.rdata, e.err, e.acc);
        end
      end
    end
    @(posedge clk); #1;
    psel[0] = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h4;
    @(posedge clk); #1;
    penable = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (pready[0]) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (!seen || prdata[0] !== 32'hA5A5_A5A5) begin
      failures++;
      $display("FAIL reset_preread got ready=%b rdata=%h want ready=1 rdata=a5a5a5a5", seen, prdata[0]);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({pready[0], pslverr[0], prdata[0], reg_out[0]} !== '0) begin
      failures++;
      $display("FAIL reset_midwait got rdy=%b err=%b rdata=%h regs=%h want all zero",
               pready[0], pslverr[0], prdata[0], reg_out[0]);
    end
    psel[0] = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    xfer_t tbl[2];
    logic [31:0] rd; logic er; int acc; logic tout; exp_t e;
    tbl = '{'{0, 1'b1, 32'h4, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0,         1'b0, 3},
            '{0, 1'b0, 32'h4, 32'h0,         4'h0, 1'b0, 32'hDEAD_BEEF, 1'b0, 3}};
    foreach (tbl[i]) begin
      exp_q.push_back('{tbl[i].rdata, tbl[i].err, tbl[i].acc});
      apb_do(tbl[i].t, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].keep, rd, er, acc, tout);
      e = exp_q.pop_front();
      checks++;
      if (tout || rd !== e.rdata || er !== e.err || acc !== e.acc) begin
        failures++;
        $display("FAIL write_read[%0d] got rdata=%h err=%b acc=%0d tout=%b want rdata=%h err=%b acc=%0d",
                 i, rd, er, acc, tout, e.rdata, e.err, e.acc);
      end
    end
    checks++;
    if (reg_out[0][63:32] !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL write_read_regout got %h want deadbeef", reg_out[0][63:32]);
    end
  endtask

  task automatic test_strobes();
    xfer_t tbl[4];
    logic [31:0] rd; logic er; int acc; logic tout; exp_t e;
    tbl = '{'{0, 1'b1, 32'h4, 32'h1122_3344, 4'b0101, 1'b0, 32'h0,         1'b0, 3},
            '{0, 1'b0, 32'h4, 32'h0,         4'h0,    1'b0, 32'hDE22_BE44, 1'b0, 3},
            '{0, 1'b1, 32'h4, 32'hFFFF_FFFF, 4'h0,    1'b0, 32'h0,         1'b0, 3},
            '{0, 1'b0, 32'h4, 32'h0,         4'h0,    1'b0, 32'hDE22_BE44, 1'b0, 3}};
    foreach (tbl[i]) begin
      exp_q.push_back('{tbl[i].rdata, tbl[i].err, tbl[i].acc});
      apb_do(tbl[i].t, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].keep, rd, er, acc, tout);
      e = exp_q.pop_front();
      checks++;
      if (tout || rd !== e.rdata || er !== e.err || acc !== e.acc) begin
        failures++;
        $display("FAIL strobes[%0d] got rdata=%h err=%b acc=%0d tout=%b want rdata=%h err=%b acc=%0d",
                 i, rd, er, acc, tout, e.rdata, e.err, e.acc);
      end
    end
  endtask

  task automatic test_errors();
    xfer_t tbl[6];
    logic [31:0] rd; logic er; int acc; logic tout; exp_t e;
    logic [255:0] want;
    status = 32'hCAFE_0123;
    tbl = '{'{0, 1'b0, 32'h20,        32'h0,         4'h0, 1'b0, 32'h0,         1'b1, 3},
            '{0, 1'b0, 32'h2,         32'h0,         4'h0, 1'b0, 32'h0,         1'b1, 3},
            '{0, 1'b1, 32'h1C,        32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0,         1'b1, 3},
            '{0, 1'b1, 32'h6,         32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0,         1'b1, 3},
            '{0, 1'b0, 32'h1C,        32'h0,         4'h0, 1'b0, 32'hCAFE_0123, 1'b0, 3},
            '{1, 1'b0, 32'h4000_00FC, 32'h0,         4'h0, 1'b0, 32'h0,         1'b1, 4}};
    foreach (tbl[i]) begin
      exp_q.push_back('{tbl[i].rdata, tbl[i].err, tbl[i].acc});
      apb_do(tbl[i].t, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].keep, rd, er, acc, tout);
      e = exp_q.pop_front();
      checks++;
      if (tout || rd !== e.rdata || er !== e.err || acc !== e.acc) begin
        failures++;
        $display("FAIL errors[%0d] got rdata=%h err=%b acc=%0d tout=%b want rdata=%h err=%b acc=%0d",
                 i, rd, er, acc, tout, e.rdata, e.err, e.acc);
      end
    end
    want = '0;
    want[63:32]   = 32'hDE22_BE44;
    want[255:224] = 32'hCAFE_0123;
    checks++;
    if (reg_out[0] !== want) begin
      failures++;
      $display("FAIL errors_regout got %h want %h", reg_out[0], want);
    end
  endtask

  task automatic test_abort();
    logic seen;
    logic [31:0] rd; logic er; int acc; logic tout; exp_t e;
    @(posedge clk); #1;
    psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h4000_0108;
    pwdata = 32'h55AA_55AA; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    seen = pready[1];
    @(posedge clk); #1;
    psel[1] = 1'b0; penable = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= pready[1];
    end
    checks++;
    if (seen !== 1'b0 || reg_out[1][95:64] !== 32'h0) begin
      failures++;
      $display("FAIL abort got ready_seen=%b reg2=%h want ready_seen=0 reg2=00000000", seen, reg_out[1][95:64]);
    end
    exp_q.push_back('{32'h0, 1'b0, 4});
    apb_do(1, 1'b0, 32'h4000_0108, 32'h0, 4'h0, 1'b0, rd, er, acc, tout);
    e = exp_q.pop_front();
    checks++;
    if (tout || rd !== e.rdata || er !== e.err || acc !== e.acc) begin
      failures++;
      $display("FAIL abort_readback got rdata=%h err=%b acc=%0d tout=%b want rdata=%h err=%b acc=%0d",
               rd, er, acc, tout, e.rdata, e.err, e.acc);
    end
  endtask

  task automatic test_back_to_back();
    xfer_t tbl[3];
    int    done_cyc[3];
    logic [31:0] rd; logic er; int acc; logic tout; exp_t e;
    tbl = '{'{2, 1'b1, 32'h1000, 32'h1, 4'hF, 1'b1, 32'h0, 1'b0, 1},
            '{2, 1'b1, 32'h1008, 32'h2, 4'hF, 1'b1, 32'h0, 1'b0, 1},
            '{2, 1'b1, 32'h100C, 32'h3, 4'hF, 1'b0, 32'h0, 1'b0, 1}};
    foreach (tbl[i]) begin
      exp_q.push_back('{tbl[i].rdata, tbl[i].err, tbl[i].acc});
      apb_do(tbl[i].t, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].keep, rd, er, acc, tout);
      if (i < 2) done_cyc[i] = cyc;
      e = exp_q.pop_front();
      checks++;
      if (tout || rd !== e.rdata || er !== e.err || acc !== e.acc) begin
        failures++;
        $display("FAIL b2b[%0d] got rdata=%h err=%b acc=%0d tout=%b want rdata=%h err=%b acc=%0d",
                 i, rd, er, acc, tout, e.rdata, e.err, e.acc);
      end
    end
    // The last transfer deasserts one cycle after its PREADY, so its PREADY cycle is cyc-1.
    done_cyc[2] = cyc - 1;
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (done_cyc[i] - done_cyc[i-1] !== 2) begin
        failures++;
        $display("FAIL b2b_spacing[%0d] got %0d cycles want 2", i, done_cyc[i] - done_cyc[i-1]);
      end
    end
    checks++;
    if (reg_out[2][127:0] !== {32'h3, 32'h2, 32'h0, 32'h1}) begin
      failures++;
      $display("FAIL b2b_regout got %h want 00000003000000020000000000000001", reg_out[2][127:0]);
    end
  endtask

  initial begin
    rst_n = 1'b0; paddr = 32'h0; pprot = 3'b010; penable = 1'b0; pwrite = 1'b0;
    pwdata = 32'h0; pstrb = 4'h0; status = 32'h0;
    for (int t = 0; t < 3; t++) psel[t] = 1'b0;
    test_reset();
    test_write_read();
    test_strobes();
    test_errors();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
